// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// datapath mux selects and the per-state control word.
package riscv_ctrl_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef logic [3:0] state_t;
    localparam state_t StFetch    = 4'd0;
    localparam state_t StDecode   = 4'd1;
    localparam state_t StMemAdr   = 4'd2;
    localparam state_t StMemRead  = 4'd3;
    localparam state_t StMemWb    = 4'd4;
    localparam state_t StMemWrite = 4'd5;
    localparam state_t StExecR    = 4'd6;
    localparam state_t StAluWb    = 4'd7;
    localparam state_t StExecI    = 4'd8;
    localparam state_t StJal      = 4'd9;
    localparam state_t StBeq      = 4'd10;
    localparam state_t StTrap     = 4'd11;

    typedef logic [1:0] alu_op_t;
    localparam alu_op_t AluAdd   = 2'b00;
    localparam alu_op_t AluSub   = 2'b01;
    localparam alu_op_t AluFunct = 2'b10;

    typedef logic [1:0] imm_src_t;
    localparam imm_src_t ImmI = 2'b00;
    localparam imm_src_t ImmS = 2'b01;
    localparam imm_src_t ImmB = 2'b10;
    localparam imm_src_t ImmJ = 2'b11;

    typedef logic [1:0] result_src_t;
    localparam result_src_t ResAluOut    = 2'b00;
    localparam result_src_t ResData      = 2'b01;
    localparam result_src_t ResAluResult = 2'b10;

    typedef logic [1:0] src_a_t;
    localparam src_a_t SrcAPc    = 2'b00;
    localparam src_a_t SrcAOldPc = 2'b01;
    localparam src_a_t SrcARs1   = 2'b10;

    typedef logic [1:0] src_b_t;
    localparam src_b_t SrcBRs2  = 2'b00;
    localparam src_b_t SrcBImm  = 2'b01;
    localparam src_b_t SrcBFour = 2'b10;

    // fetch: IR/PC enables that still need the memory ready qualifier
    typedef struct packed {
        logic        fetch;
        logic        pc_update;
        logic        branch;
        logic        adr_src;
        logic        mem_write;
        logic        reg_write;
        result_src_t result_src;
        src_a_t      alu_src_a;
        src_b_t      alu_src_b;
        alu_op_t     alu_op;
        logic        illegal;
    } ctrl_word_t;

    function automatic imm_src_t imm_src_of(logic [6:0] opcode);
        case (opcode)
            OpStore:  return ImmS;
            OpBranch: return ImmB;
            OpJal:    return ImmJ;
            default:  return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control-unit bundle: opcode/flags from the datapath, enables and selects back to it.
interface multicycle_controller_if;
    import riscv_ctrl_pkg::*;

    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        adr_src;
    logic        ir_write;
    logic        mem_write;
    logic        reg_write;
    result_src_t result_src;
    src_a_t      alu_src_a;
    src_b_t      alu_src_b;
    alu_op_t     alu_op;
    imm_src_t    imm_src;
    logic        illegal;
    state_t      state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, illegal, state
    );

endinterface

// File: rtl/ctrl_output_rom.sv
// Moore decode of the controller state into the datapath control word.
module ctrl_output_rom
    import riscv_ctrl_pkg::*;
(
    input  state_t     i_state,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            StFetch: begin
                o_ctrl.fetch      = 1'b1;
                o_ctrl.alu_src_a  = SrcAPc;
                o_ctrl.alu_src_b  = SrcBFour;
                o_ctrl.alu_op     = AluAdd;
                o_ctrl.result_src = ResAluResult;
            end
            StDecode: begin
                o_ctrl.alu_src_a = SrcAOldPc;
                o_ctrl.alu_src_b = SrcBImm;
                o_ctrl.alu_op    = AluAdd;
            end
            StMemAdr: begin
                o_ctrl.alu_src_a = SrcARs1;
                o_ctrl.alu_src_b = SrcBImm;
                o_ctrl.alu_op    = AluAdd;
            end
            StExecI: begin
                o_ctrl.alu_src_a = SrcARs1;
                o_ctrl.alu_src_b = SrcBImm;
                o_ctrl.alu_op    = AluFunct;
            end
            StMemRead: begin
                o_ctrl.adr_src    = 1'b1;
                o_ctrl.result_src = ResAluOut;
            end
            StMemWrite: begin
                o_ctrl.adr_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            StMemWb: begin
                o_ctrl.result_src = ResData;
                o_ctrl.reg_write  = 1'b1;
            end
            StExecR: begin
                o_ctrl.alu_src_a = SrcARs1;
                o_ctrl.alu_src_b = SrcBRs2;
                o_ctrl.alu_op    = AluFunct;
            end
            StAluWb: begin
                o_ctrl.result_src = ResAluOut;
                o_ctrl.reg_write  = 1'b1;
            end
            StJal: begin
                o_ctrl.alu_src_a  = SrcAOldPc;
                o_ctrl.alu_src_b  = SrcBFour;
                o_ctrl.alu_op     = AluAdd;
                o_ctrl.result_src = ResAluOut;
                o_ctrl.pc_update  = 1'b1;
            end
            StBeq: begin
                o_ctrl.alu_src_a  = SrcARs1;
                o_ctrl.alu_src_b  = SrcBRs2;
                o_ctrl.alu_op     = AluSub;
                o_ctrl.result_src = ResAluOut;
                o_ctrl.branch     = 1'b1;
            end
            StTrap: o_ctrl.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: state register, opcode dispatch and memory handshake gating.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit SUPPORT_JAL   = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    multicycle_controller_if.master        io_ctrl
);

    state_t     r_state;
    state_t     w_state_next;
    state_t     w_rom_state;
    ctrl_word_t w_ctrl;
    logic       w_ready;
    logic       w_accept;

    assign w_ready = MEM_HANDSHAKE ? io_ctrl.mem_ready : 1'b1;

    always_comb begin
        w_state_next = StFetch;
        case (r_state)
            StFetch: w_state_next = w_ready ? StDecode : StFetch;
            StDecode: begin
                case (io_ctrl.opcode)
                    OpLoad, OpStore: w_state_next = StMemAdr;
                    OpRtype:         w_state_next = StExecR;
                    OpItype:         w_state_next = StExecI;
                    OpBranch:        w_state_next = StBeq;
                    OpJal:           w_state_next = SUPPORT_JAL ? StJal : StTrap;
                    default:         w_state_next = StTrap;
                endcase
            end
            StMemAdr:   w_state_next = (io_ctrl.opcode == OpStore) ? StMemWrite : StMemRead;
            StMemRead:  w_state_next = w_ready ? StMemWb : StMemRead;
            StMemWrite: w_state_next = w_ready ? StFetch : StMemWrite;
            StExecR, StExecI, StJal: w_state_next = StAluWb;
            StTrap:     w_state_next = StTrap;
            default:    w_state_next = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Decoding FETCH during reset parks the muxes and kills every non-fetch enable.
    assign w_rom_state = rst ? StFetch : r_state;

    ctrl_output_rom u_rom (
        .i_state (w_rom_state),
        .o_ctrl  (w_ctrl)
    );

    assign w_accept = w_ctrl.fetch & w_ready & ~rst;

    assign io_ctrl.ir_write   = w_accept;
    assign io_ctrl.pc_write   = w_accept | w_ctrl.pc_update | (w_ctrl.branch & io_ctrl.zero);
    assign io_ctrl.adr_src    = w_ctrl.adr_src;
    assign io_ctrl.mem_write  = w_ctrl.mem_write;
    assign io_ctrl.reg_write  = w_ctrl.reg_write;
    assign io_ctrl.result_src = w_ctrl.result_src;
    assign io_ctrl.alu_src_a  = w_ctrl.alu_src_a;
    assign io_ctrl.alu_src_b  = w_ctrl.alu_src_b;
    assign io_ctrl.alu_op     = w_ctrl.alu_op;
    assign io_ctrl.illegal    = w_ctrl.illegal;
    assign io_ctrl.imm_src    = imm_src_of(io_ctrl.opcode);
    assign io_ctrl.state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cycle table, trap/reset/jal sequences and
// randomized instruction streams checked against a step-list reference model.
module tb_multicycle_controller;

    localparam logic [6:0] OLW  = 7'b0000011;
    localparam logic [6:0] OSW  = 7'b0100011;
    localparam logic [6:0] ORT  = 7'b0110011;
    localparam logic [6:0] OIT  = 7'b0010011;
    localparam logic [6:0] OBQ  = 7'b1100011;
    localparam logic [6:0] OJL  = 7'b1101111;
    localparam logic [6:0] OBAD = 7'b1111111;

    localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMWB = 4, SMW = 5;
    localparam int SER = 6, SAW = 7, SEI = 8, SJ = 9, SB = 10, ST = 11;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic [6:0] opc;
        logic       zero;
        logic       rdy;
        ctl_t       exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    int         errors;
    int         checks;
    ctl_t       act_main;
    ctl_t       act_nj;
    vec_t       vecs[$];

    int         plan_st[$];
    bit         plan_wait[$];
    int         idx;
    int         trap_cnt;
    int         trap_limit;
    logic [6:0] cur_opc;

    multicycle_controller_if bus ();
    multicycle_controller_if bus_nj ();

    assign bus.opcode       = opcode;
    assign bus.zero         = zero;
    assign bus.mem_ready    = mem_ready;
    assign bus_nj.opcode    = opcode;
    assign bus_nj.zero      = zero;
    assign bus_nj.mem_ready = mem_ready;

    multicycle_controller u_dut (
        .clk     (clk),
        .rst     (rst),
        .io_ctrl (bus)
    );

    multicycle_controller #(
        .MEM_HANDSHAKE (1'b1),
        .SUPPORT_JAL   (1'b0)
    ) u_dut_nojal (
        .clk     (clk),
        .rst     (rst),
        .io_ctrl (bus_nj)
    );

    assign act_main = {bus.state, bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write,
                       bus.adr_src, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                       bus.imm_src, bus.illegal};
    assign act_nj   = {bus_nj.state, bus_nj.pc_write, bus_nj.ir_write, bus_nj.mem_write,
                       bus_nj.reg_write, bus_nj.adr_src, bus_nj.result_src, bus_nj.alu_src_a,
                       bus_nj.alu_src_b, bus_nj.alu_op, bus_nj.imm_src, bus_nj.illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Argument order: state pcw irw mw rw adr result_src alu_src_a alu_src_b alu_op imm ill
    function automatic ctl_t mk(int st, int pcw, int irw, int mw, int rw, int adr, int rs,
                                int asa, int asb, int aop, int imm, int ill);
        ctl_t c;
        c.state      = st[3:0];
        c.pc_write   = pcw[0];
        c.ir_write   = irw[0];
        c.mem_write  = mw[0];
        c.reg_write  = rw[0];
        c.adr_src    = adr[0];
        c.result_src = rs[1:0];
        c.alu_src_a  = asa[1:0];
        c.alu_src_b  = asb[1:0];
        c.alu_op     = aop[1:0];
        c.imm_src    = imm[1:0];
        c.illegal    = ill[0];
        return c;
    endfunction

    function automatic string fmt(ctl_t c);
        return $sformatf("st=%0d pcw=%b irw=%b mw=%b rw=%b adr=%b rs=%0d a=%0d b=%0d op=%0d imm=%0d ill=%b",
                         c.state, c.pc_write, c.ir_write, c.mem_write, c.reg_write, c.adr_src,
                         c.result_src, c.alu_src_a, c.alu_src_b, c.alu_op, c.imm_src, c.illegal);
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] o);
        case (o)
            OSW:     return 2'd1;
            OBQ:     return 2'd2;
            OJL:     return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Expected outputs for a state the model believes the controller is in.
    function automatic ctl_t model_out(int st, logic r, logic d, logic z, logic [6:0] o);
        ctl_t c = '0;
        c.state   = st[3:0];
        c.imm_src = imm_of(o);
        if (r) begin
            c.alu_src_b  = 2'd2;
            c.result_src = 2'd2;
            return c;
        end
        case (st)
            SF:   begin c.pc_write = d; c.ir_write = d; c.alu_src_b = 2'd2; c.result_src = 2'd2; end
            SD:   begin c.alu_src_a = 2'd1; c.alu_src_b = 2'd1; end
            SMA:  begin c.alu_src_a = 2'd2; c.alu_src_b = 2'd1; end
            SEI:  begin c.alu_src_a = 2'd2; c.alu_src_b = 2'd1; c.alu_op = 2'd2; end
            SMR:  c.adr_src = 1'b1;
            SMW:  begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            SMWB: begin c.result_src = 2'd1; c.reg_write = 1'b1; end
            SER:  begin c.alu_src_a = 2'd2; c.alu_op = 2'd2; end
            SAW:  c.reg_write = 1'b1;
            SJ:   begin c.alu_src_a = 2'd1; c.alu_src_b = 2'd2; c.pc_write = 1'b1; end
            SB:   begin c.alu_src_a = 2'd2; c.alu_op = 2'd1; c.pc_write = z; end
            ST:   c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic add(int r, logic [6:0] o, int z, int d, ctl_t e);
        vecs.push_back('{rst: r[0], opc: o, zero: z[0], rdy: d[0], exp: e});
    endtask

    task automatic check(input string name, input ctl_t act, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    // Drive inputs just after a rising edge and move to the falling edge for sampling.
    task automatic drive(input logic r, input logic [6:0] o, input logic z, input logic d);
        rst       = r;
        opcode    = o;
        zero      = z;
        mem_ready = d;
        @(negedge clk);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, OLW, 1'b0, 1'b1);
            next_edge();
        end
    endtask

    task automatic add_step(int s, bit w);
        plan_st.push_back(s);
        plan_wait.push_back(w);
    endtask

    // Each instruction is an ordered list of states; wait steps stall while mem_ready is low.
    task automatic new_instr();
        int k;
        k = $urandom_range(0, 15);
        plan_st.delete();
        plan_wait.delete();
        idx        = 0;
        trap_cnt   = 0;
        trap_limit = $urandom_range(1, 5);
        add_step(SF, 1'b1);
        add_step(SD, 1'b0);
        if (k < 3) begin
            cur_opc = OLW;
            add_step(SMA, 1'b0); add_step(SMR, 1'b1); add_step(SMWB, 1'b0);
        end else if (k < 6) begin
            cur_opc = OSW;
            add_step(SMA, 1'b0); add_step(SMW, 1'b1);
        end else if (k < 8) begin
            cur_opc = ORT;
            add_step(SER, 1'b0); add_step(SAW, 1'b0);
        end else if (k < 10) begin
            cur_opc = OIT;
            add_step(SEI, 1'b0); add_step(SAW, 1'b0);
        end else if (k < 12) begin
            cur_opc = OBQ;
            add_step(SB, 1'b0);
        end else if (k < 14) begin
            cur_opc = OJL;
            add_step(SJ, 1'b0); add_step(SAW, 1'b0);
        end else begin
            case ($urandom_range(0, 3))
                0:       cur_opc = OBAD;
                1:       cur_opc = 7'b0110111;
                2:       cur_opc = 7'b0000000;
                default: cur_opc = 7'b1100111;
            endcase
            add_step(ST, 1'b0);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        opcode    = OLW;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // lw, zero wait
        add(1, OLW, 0, 1, mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        add(0, OLW, 0, 1, mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        add(0, OLW, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        add(0, OLW, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        add(0, OLW, 0, 1, mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add(0, OLW, 0, 1, mk(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        // sw, one fetch wait, three MEMWRITE waits
        add(0, OSW, 0, 0, mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 0));
        add(0, OSW, 0, 1, mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 1, 0));
        add(0, OSW, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
        add(0, OSW, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        add(0, OSW, 0, 0, mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        add(0, OSW, 0, 0, mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        add(0, OSW, 0, 0, mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        add(0, OSW, 0, 1, mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        // beq taken
        add(0, OBQ, 1, 1, mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 2, 0));
        add(0, OBQ, 1, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0));
        add(0, OBQ, 1, 1, mk(10, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0));
        // beq not taken
        add(0, OBQ, 1, 1, mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 2, 0));
        add(0, OBQ, 1, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0));
        add(0, OBQ, 0, 1, mk(10, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0));
        // jal; mem_ready low must not gate the JAL PC write
        add(0, OJL, 0, 1, mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 3, 0));
        add(0, OJL, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0));
        add(0, OJL, 0, 0, mk(9, 1, 0, 0, 0, 0, 0, 1, 2, 0, 3, 0));
        add(0, OJL, 0, 1, mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0));
        // R-type
        add(0, ORT, 0, 1, mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        add(0, ORT, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        add(0, ORT, 1, 1, mk(6, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
        add(0, ORT, 0, 1, mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // addi
        add(0, OIT, 0, 1, mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        add(0, OIT, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        add(0, OIT, 0, 1, mk(8, 0, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0));
        add(0, OIT, 0, 1, mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // sw aborted by reset while stalled in MEMWRITE
        add(0, OSW, 0, 1, mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 1, 0));
        add(0, OSW, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
        add(0, OSW, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        add(0, OSW, 0, 0, mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        add(1, OSW, 0, 0, mk(5, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 0));
        add(0, OSW, 0, 0, mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 0));
        // illegal opcode into TRAP
        add(0, OBAD, 0, 1, mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        add(0, OBAD, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        add(0, OBAD, 1, 1, mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].opc, vecs[i].zero, vecs[i].rdy);
            check($sformatf("vec%0d", i), act_main, vecs[i].exp);
            next_edge();
        end

        // TRAP is sticky whatever the inputs do
        for (int i = 0; i < 20; i++) begin
            logic z;
            logic d;
            z = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 1) == 1);
            drive(1'b0, OBAD, z, d);
            check($sformatf("trap%0d", i), act_main, mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            next_edge();
        end
        drive(1'b1, OBAD, 1'b1, 1'b1);
        check("trap_rst", act_main, mk(11, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        next_edge();
        drive(1'b0, OBAD, 1'b0, 1'b0);
        check("trap_exit", act_main, mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        next_edge();

        // jal on both builds: supported path vs trap
        do_reset();
        drive(1'b0, OJL, 1'b0, 1'b1);
        next_edge();
        drive(1'b0, OJL, 1'b0, 1'b1);
        check("nojal_decode", act_nj, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0));
        next_edge();
        drive(1'b0, OJL, 1'b0, 1'b1);
        check("jal_state", act_main, mk(9, 1, 0, 0, 0, 0, 0, 1, 2, 0, 3, 0));
        check("nojal_trap", act_nj, mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
        next_edge();
        drive(1'b0, OJL, 1'b0, 1'b1);
        check("jal_aluwb", act_main, mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0));
        check("nojal_stay", act_nj, mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
        next_edge();

        // Randomized instruction stream against the step-list model
        do_reset();
        new_instr();
        for (int cyc = 0; cyc < 2500; cyc++) begin
            logic r;
            logic d;
            logic z;
            ctl_t e;
            r = (plan_st[idx] == ST && trap_cnt >= trap_limit) || ($urandom_range(0, 59) == 0);
            d = ($urandom_range(0, 3) != 0);
            z = ($urandom_range(0, 1) == 1);
            drive(r, cur_opc, z, d);
            e = model_out(plan_st[idx], r, d, z, cur_opc);
            check($sformatf("rand%0d", cyc), act_main, e);
            next_edge();
            if (r) begin
                new_instr();
            end else if (plan_st[idx] == ST) begin
                trap_cnt++;
            end else if (!(plan_wait[idx] && !d)) begin
                idx++;
                if (idx == plan_st.size()) new_instr();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
